// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of mem_port_arbiter.
// slave is the arbiter's view; master is the requester/memory environment.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_PORTS  = 2
);
  localparam int SW = DATA_WIDTH / 8;

  logic [NUM_PORTS-1:0]            req_valid;
  logic [NUM_PORTS-1:0]            req_ready;
  logic [NUM_PORTS-1:0]            req_we;
  logic [NUM_PORTS*SW-1:0]         req_strb;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;

  logic [NUM_PORTS-1:0]            rsp_valid;
  logic                            rsp_err;
  logic [DATA_WIDTH-1:0]           rsp_rdata;

  logic                            mem_write_en;
  logic                            mem_read_en;
  logic [SW-1:0]                   mem_strb;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic                            mem_w_success;
  logic                            mem_r_success;
  logic [DATA_WIDTH-1:0]           mem_rdata;

  modport slave (
    input  req_valid, req_we, req_strb,
    input  req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_err, rsp_rdata,
    output mem_write_en, mem_read_en,
    output mem_strb, mem_addr, mem_wdata,
    input  mem_w_success, mem_r_success,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_we, req_strb,
    output req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_err, rsp_rdata,
    input  mem_write_en, mem_read_en,
    input  mem_strb, mem_addr, mem_wdata,
    output mem_w_success, mem_r_success,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: N requesters onto one memory port, IDLE/ISSUE/RESP with timeout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is fixed low-index priority.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_PORTS  = 2,
  parameter int TIMEOUT    = 15
) (
  input logic               clk,
  input logic               arst,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t                  state;
  logic [IW-1:0]           owner;
  logic [IW-1:0]           win;
  logic                    any;
  logic [NUM_PORTS-1:0]    ready;
  logic [7:0]              cnt;
  logic                    done;
  logic                    expired;

  logic                    wr_en;
  logic                    rd_en;
  logic [SW-1:0]           strb;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [NUM_PORTS-1:0]    rsp_valid;
  logic                    rsp_err;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr;

  function automatic logic [IW-1:0] nxt(
    input logic [IW-1:0] p,
    input int            off
  );
    int s;
    s = int'(p) + off;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return IW'(s);
  endfunction

  // search upward from the port after the last grant, wrapping
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      if (!any && bus.req_valid[nxt(ptr, off)]) begin
        win = nxt(ptr, off);
        any = 1'b1;
      end
    end
  end
`else
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        win = IW'(i);
        any = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    ready = '0;
    if (state == IDLE && any) ready[win] = 1'b1;
  end

  // only the success type matching the latched request counts
  assign done    = (wr_en & bus.mem_w_success)
                 | (rd_en & bus.mem_r_success);
  assign expired = (cnt == TMO_LAST);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      owner     <= '0;
      cnt       <= '0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      strb      <= '0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr       <= IW'(NUM_PORTS - 1);
`endif
    end else begin
      rsp_valid <= '0;
      unique case (state)
        IDLE: begin
          if (any) begin
            owner <= win;
            wr_en <= bus.req_we[win];
            rd_en <= !bus.req_we[win];
            strb  <= bus.req_we[win]
                   ? bus.req_strb[int'(win)*SW +: SW]
                   : '1;
            addr  <= bus.req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
            wdata <= bus.req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
            cnt   <= '0;
            state <= ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr   <= win;
`endif
          end
        end
        ISSUE: begin
          if (done || expired) begin
            wr_en            <= 1'b0;
            rd_en            <= 1'b0;
            rsp_valid[owner] <= 1'b1;
            state            <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
          if (done) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= rd_en ? bus.mem_rdata : '0;
          end else if (expired) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready    = ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_err      = rsp_err;
  assign bus.rsp_rdata    = rsp_rdata;
  assign bus.mem_write_en = wr_en;
  assign bus.mem_read_en  = rd_en;
  assign bus.mem_strb     = strb;
  assign bus.mem_addr     = addr;
  assign bus.mem_wdata    = wdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and random
// transactions checked against a request-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NP = 2;
  localparam int TO = 15;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic arst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(NP)
  ) bus ();

  mem_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .NUM_PORTS(NP), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .arst(arst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int last  = NP - 1;

  typedef struct {
    int              port;
    logic            we;
    logic [SW-1:0]   strb;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    int              lat;
    logic [DW-1:0]   rd;
    bit              wrong;
    bit              exp_err;
    logic [DW-1:0]   exp_rd;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NP-1:0] oh(input int p);
    logic [NP-1:0] m;
    m = '0;
    m[p] = 1'b1;
    return m;
  endfunction

  // model winner: lowest index, or first requester after the last grant
  function automatic int pick(input logic [NP-1:0] m);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= NP; k++)
      if (m[(last + k) % NP]) return (last + k) % NP;
`else
    for (int k = 0; k < NP; k++)
      if (m[k]) return k;
`endif
    return -1;
  endfunction

  task automatic clear_inputs();
    bus.req_valid     = '0;
    bus.req_we        = '0;
    bus.req_strb      = '0;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.mem_w_success = 1'b0;
    bus.mem_r_success = 1'b0;
    bus.mem_rdata     = '0;
  endtask

  task automatic set_port(input int p, input logic we,
                          input logic [SW-1:0] s, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    bus.req_we[p]                = we;
    bus.req_strb[p*SW +: SW]     = s;
    bus.req_addr[p*AW +: AW]     = a;
    bus.req_wdata[p*DW +: DW]    = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    arst = 1'b1;
    #1;
    check("rst_ctrl", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_err,
          bus.mem_write_en, bus.mem_read_en, bus.mem_strb}), 64'(0));
    check("rst_rdata", 64'(bus.rsp_rdata), 64'(0));
    check("rst_mem", 64'({bus.mem_addr, bus.mem_wdata}), 64'(0));
    @(negedge clk);
    arst = 1'b0;
    last = NP - 1;
  endtask

  // one request from IDLE to the cycle after RESP
  task automatic txn(input logic [NP-1:0] mask, input int port,
                     input int lat, input logic [DW-1:0] rd,
                     input bit wrong, input bit exp_err,
                     input logic [DW-1:0] exp_rd);
    logic          ewe;
    logic [SW-1:0] es;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    int            nend;
    ewe  = bus.req_we[port];
    es   = ewe ? bus.req_strb[port*SW +: SW] : '1;
    ea   = bus.req_addr[port*AW +: AW];
    ed   = bus.req_wdata[port*DW +: DW];
    nend = (lat >= 1 && lat <= TO) ? lat : TO;
    @(negedge clk);
    bus.req_valid = mask;
    #1;
    check("grant", 64'(bus.req_ready), 64'(oh(port)));
    @(negedge clk);
    bus.req_valid = '0;
    for (int n = 1; n <= nend; n++) begin
      if (n > 1) @(negedge clk);
      bus.mem_w_success = 1'b0;
      bus.mem_r_success = 1'b0;
      bus.mem_rdata     = ~rd;
      if (n == lat) begin
        if (ewe) bus.mem_w_success = 1'b1;
        else     bus.mem_r_success = 1'b1;
        bus.mem_rdata = rd;
      end else if (wrong && (n % 2 == 1)) begin
        if (ewe) bus.mem_r_success = 1'b1;
        else     bus.mem_w_success = 1'b1;
      end
      #1;
      check("issue_en", 64'({bus.mem_write_en, bus.mem_read_en}),
            64'({ewe, !ewe}));
      check("issue_strb", 64'(bus.mem_strb), 64'(es));
      check("issue_addr", 64'(bus.mem_addr), 64'(ea));
      if (ewe) check("issue_wdata", 64'(bus.mem_wdata), 64'(ed));
      check("issue_quiet", 64'({bus.rsp_valid, bus.req_ready}), 64'(0));
    end
    @(negedge clk);
    bus.mem_w_success = 1'b0;
    bus.mem_r_success = 1'b0;
    bus.mem_rdata     = ~rd;
    bus.req_valid     = '1;
    #1;
    check("resp_valid", 64'(bus.rsp_valid), 64'(oh(port)));
    check("resp_err", 64'(bus.rsp_err), 64'(exp_err));
    check("resp_rdata", 64'(bus.rsp_rdata), 64'(exp_rd));
    check("resp_quiet", 64'({bus.req_ready, bus.mem_write_en,
          bus.mem_read_en}), 64'(0));
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("resp_hold", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}),
          64'({exp_err, exp_rd}));
    last = port;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [NP-1:0] mask;
    int            port;
    int            lat;
    int            exp_p;
    logic [DW-1:0] rd;
    bit            wrong;
    bit            e_err;
    logic [DW-1:0] e_rd;
    bit            got;
    bit            pulsed;

    vecs[0] = '{1, 1'b0, 4'hF, 32'h100, 32'h0, 2,
                32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{0, 1'b1, 4'b0011, 32'h40, 32'h12345678, 3,
                32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{0, 1'b0, 4'h0, 32'h200, 32'h0, 0,
                32'h11111111, 1'b1, 1'b1, 32'h0};
    vecs[3] = '{1, 1'b0, 4'h0, 32'h304, 32'h0, 15,
                32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D};
    vecs[4] = '{1, 1'b1, 4'hF, 32'h808, 32'hA5A5A5A5, 1,
                32'h77777777, 1'b0, 1'b0, 32'h0};
    vecs[5] = '{0, 1'b0, 4'b0101, 32'hC, 32'h0, 1,
                32'h0BADF00D, 1'b0, 1'b0, 32'h0BADF00D};
    vecs[6] = '{1, 1'b1, 4'b1000, 32'hFFC, 32'h1, 16,
                32'h2, 1'b1, 1'b1, 32'h0};

    arst = 1'b1;
    clear_inputs();
    do_reset();

    foreach (vecs[i]) begin
      set_port(vecs[i].port, vecs[i].we, vecs[i].strb,
               vecs[i].addr, vecs[i].wdata);
      txn(oh(vecs[i].port), vecs[i].port, vecs[i].lat, vecs[i].rd,
          vecs[i].wrong, vecs[i].exp_err, vecs[i].exp_rd);
    end

    // both ports requesting back to back
    do_reset();
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, '0, AW'(p * 16), '0);
    @(negedge clk);
    bus.req_valid = '1;
    for (int g = 0; g < 4; g++) begin
      exp_p = pick('1);
      got = 1'b0;
      for (int w = 0; w < 8; w++) begin
        #1;
        if (bus.req_ready != '0) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check("arb_grant", 64'(bus.req_ready), 64'(oh(exp_p)));
      check("arb_got", 64'(got), 64'(1));
      last = exp_p;
      @(negedge clk);
      bus.mem_r_success = 1'b1;
      bus.mem_rdata     = DW'(g);
      @(negedge clk);
      bus.mem_r_success = 1'b0;
      #1;
      check("arb_rsp", 64'(bus.rsp_valid), 64'(oh(exp_p)));
      @(negedge clk);
    end
    bus.req_valid = '0;

    // reset asserted in the middle of ISSUE
    do_reset();
    set_port(1, 1'b0, '0, 32'h500, '0);
    @(negedge clk);
    bus.req_valid = 2'b10;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("abort_pre_en", 64'(bus.mem_read_en), 64'(1));
    @(negedge clk);
    #1;
    arst = 1'b1;
    #1;
    check("abort_en_drop", 64'({bus.mem_write_en, bus.mem_read_en}),
          64'(0));
    @(negedge clk);
    arst = 1'b0;
    pulsed = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (bus.rsp_valid != '0) pulsed = 1'b1;
    end
    check("abort_no_rsp", 64'(pulsed), 64'(0));
    last = NP - 1;
    set_port(0, 1'b0, '0, 32'h600, '0);
    set_port(1, 1'b0, '0, 32'h700, '0);
    txn('1, pick('1), 2, 32'h13579BDF, 1'b0, 1'b0, 32'h13579BDF);

    // random traffic against the request-level model
    for (int t = 0; t < 40; t++) begin
      for (int p = 0; p < NP; p++)
        set_port(p, 1'($urandom_range(0, 1)), SW'($urandom),
                 AW'($urandom), DW'($urandom));
      mask  = NP'($urandom_range(1, (1 << NP) - 1));
      port  = pick(mask);
      lat   = $urandom_range(1, TO + 2);
      rd    = DW'($urandom);
      wrong = 1'($urandom_range(0, 1));
      e_err = !(lat >= 1 && lat <= TO);
      e_rd  = (e_err || bus.req_we[port]) ? '0 : rd;
      txn(mask, port, lat, rd, wrong, e_err, e_rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, data bus width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, 32, address width in bits.
REQ-003 Parameter NUM_PORTS, 2, number of requesters; legal range 1..8; port 0 is fetch, port 1 is LSU.
REQ-004 Parameter TIMEOUT, 15, maximum number of ISSUE cycles before error; legal range 1..255.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 arst  in  1  reset; asynchronous, active-high.
REQ-007 req_valid  in  NUM_PORTS  per-port request present.
REQ-008 req_ready  out  NUM_PORTS  per-port request accepted this cycle.
REQ-009 req_we  in  NUM_PORTS  per-port request type: 1 = write, 0 = read.
REQ-010 req_strb  in  NUM_PORTS*DATA_WIDTH/8  per-port byte strobes; port i occupies slice i.
REQ-011 req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address.
REQ-012 req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
REQ-013 rsp_valid  out  NUM_PORTS  one-cycle completion pulse to the owning port.
REQ-014 rsp_err  out  1  completion ended in timeout; valid only while any rsp_valid bit is set.
REQ-015 rsp_rdata  out  DATA_WIDTH  read data; valid only while any rsp_valid bit is set.
REQ-016 mem_write_en, mem_read_en  out  1 each  memory write and read enables.
REQ-017 mem_strb  out  DATA_WIDTH/8, mem_addr  out  ADDR_WIDTH, mem_wdata  out  DATA_WIDTH  memory request fields.
REQ-018 mem_w_success, mem_r_success  in  1 each, mem_rdata  in  DATA_WIDTH  memory completion and read data.

Function
REQ-019 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-020 IDLE: when any req_valid bit is set, the block SHALL raise req_ready for exactly one winning port in that cycle, latch the winner's we/strb/addr/wdata and index, and move to ISSUE.
REQ-021 req_ready SHALL be combinational, asserted only in IDLE, and at most one-hot.
REQ-022 ISSUE: mem_write_en (if we=1) or mem_read_en (if we=0) SHALL be held high with the latched fields until completion; mem_strb SHALL be all ones for reads.
REQ-023 Completion: a write SHALL complete on mem_w_success and a read on mem_r_success; a success of the wrong type SHALL be ignored.
REQ-024 On completion, the block SHALL register mem_rdata (reads) or 0 (writes), set rsp_err=0, and move to RESP.
REQ-025 The timeout counter SHALL clear on entry to ISSUE; if it reaches TIMEOUT without completion, the block SHALL move to RESP with rsp_err=1 and rsp_rdata=0.
REQ-026 If success and timeout occur in the same cycle, success SHALL take priority.
REQ-027 RESP: the block SHALL pulse rsp_valid[owner] for one cycle, drive both mem enables low, and return to IDLE; no grant SHALL be issued in RESP.
REQ-028 Latency: grant in cycle 0, enables high from cycle 1, success in cycle k, rsp_valid in cycle k+1; minimum turnaround is 3 cycles per request.
REQ-029 Outside ISSUE, mem_write_en and mem_read_en SHALL be 0.
REQ-030 rsp_rdata and rsp_err SHALL hold their values until the next RESP.

Reset
REQ-031 While arst is high, the state SHALL be IDLE and all outputs 0: req_ready, rsp_valid, rsp_err, rsp_rdata, and mem_*.
REQ-032 An arst asserted mid-transaction SHALL abort the transaction with no rsp_valid, and the enables SHALL drop without waiting for clk.
REQ-033 On reset, the round-robin pointer SHALL be NUM_PORTS-1, so that port 0 wins the first contention.

Configuration
REQ-034 With MEM_ARB_ROUND_ROBIN_EN defined, the winner SHALL be the first requesting port after the last granted port, searching upward with wrap-around; the pointer SHALL update only on grant.
REQ-035 Without MEM_ARB_ROUND_ROBIN_EN, the lowest-index requesting port SHALL always win, and no pointer register SHALL be built.

Verification
REQ-036 Single read on port 1 at addr 0x100, mem_r_success after 2 cycles with rdata 0xDEADBEEF -> rsp_valid=2'b10 once, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-037 Write on port 0 with strb 4'b0011 -> mem_write_en high with mem_strb=4'b0011 until mem_w_success; a mem_r_success pulse during ISSUE is ignored.
REQ-038 Both ports requesting continuously, MEM_ARB_ROUND_ROBIN_EN defined -> grants 0,1,0,1; without the macro -> grants 0,0,0,0.
REQ-039 No success for TIMEOUT=15 cycles -> rsp_err=1 and rsp_rdata=0 in the cycle after the 15th ISSUE cycle; success arriving on cycle 15 -> rsp_err=0.
REQ-040 arst pulsed during ISSUE -> enables drop immediately, no rsp_valid, and the next request is granted normally to port 0.
